// File: rtl/io_timer_block.sv
// io_timer_block: register-mapped down-counting timer with a prescaler,
// one-shot / auto-reload modes and a level interrupt on expiry.
module io_timer_block #(
  parameter int COUNT_WIDTH    = 32,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        BlockSelect,
  input  logic [3:0]  RegAddress,
  input  logic        WrEn,
  input  logic        RdEn,
  input  logic [31:0] WrData,
  output logic [31:0] RdData,
  output logic        Irq
);

  localparam logic [3:0] A_CTRL     = 4'h0;
  localparam logic [3:0] A_LOAD     = 4'h1;
  localparam logic [3:0] A_COUNT    = 4'h2;
  localparam logic [3:0] A_STATUS   = 4'h3;
  localparam logic [3:0] A_PRESCALE = 4'h4;

  logic                      en, auto_rld, irq_en, expired;
  logic [COUNT_WIDTH-1:0]    load, count;
  logic [PRESCALE_WIDTH-1:0] prescale, pcnt;

  logic wr, ctrl_wr, load_wr, status_wr, pre_wr;
  logic start, stop, tick, tick_eff, expiry;

  // Reads have no side effects, so the read strobe is deliberately unused.
  logic unused_rd;
  assign unused_rd = RdEn;

  assign wr        = BlockSelect & WrEn;
  assign ctrl_wr   = wr & (RegAddress == A_CTRL);
  assign load_wr   = wr & (RegAddress == A_LOAD);
  assign status_wr = wr & (RegAddress == A_STATUS);
  assign pre_wr    = wr & (RegAddress == A_PRESCALE);

  // start: enable 0->1 restart; stop: enable written 0 (discards a same-cycle tick)
  assign start    = ctrl_wr &  WrData[0] & ~en;
  assign stop     = ctrl_wr & ~WrData[0];
  assign tick     = en & (pcnt == prescale);
  assign tick_eff = tick & ~stop;
  assign expiry   = tick_eff & (count == '0);

  // Control bits; a one-shot expiry drops Enable using the pre-write AutoReload
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      en       <= 1'b0;
      auto_rld <= 1'b0;
      irq_en   <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        en       <= WrData[0];
        auto_rld <= WrData[1];
        irq_en   <= WrData[2];
      end
      if (expiry && !auto_rld) en <= 1'b0;
    end
  end

  // LOAD and PRESCALE holding registers
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      load     <= '0;
      prescale <= '0;
    end else begin
      if (load_wr) load     <= WrData[COUNT_WIDTH-1:0];
      if (pre_wr)  prescale <= WrData[PRESCALE_WIDTH-1:0];
    end
  end

  // Prescaler: free increment while enabled, cleared on tick; wraps naturally
  // if PRESCALE was lowered below the current value
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)             pcnt <= '0;
    else if (start)         pcnt <= '0;
    else if (en && !stop)   pcnt <= tick ? '0 : pcnt + 1'b1;
  end

  // Down-counter: restart loads LOAD, tick decrements or reloads at zero
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)             count <= '0;
    else if (start)         count <= load;
    else if (tick_eff) begin
      if (count != '0)      count <= count - 1'b1;
      else if (auto_rld)    count <= load;
    end
  end

  // Expired sticky flag; a same-cycle expiry beats the write-1-to-clear
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)                       expired <= 1'b0;
    else if (expiry)                  expired <= 1'b1;
    else if (status_wr && WrData[0])  expired <= 1'b0;
  end

  // Combinational read mux, independent of the strobes
  always_comb begin
    RdData = '0;
    case (RegAddress)
      A_CTRL:     RdData[2:0] = {irq_en, auto_rld, en};
      A_LOAD:     RdData[COUNT_WIDTH-1:0] = load;
      A_COUNT:    RdData[COUNT_WIDTH-1:0] = count;
      A_STATUS:   RdData[1:0] = {en, expired};
      A_PRESCALE: RdData[PRESCALE_WIDTH-1:0] = prescale;
      default:    RdData = '0;
    endcase
  end

  assign Irq = expired & irq_en;

endmodule
